// File: rtl/rv_pkg.sv
// rv_pkg: shared core constants plus the address-translator table types.
//   RV_XLEN / RV_MEM_LEN : core and on-chip memory address widths
//   RV_MEM_GATE          : boundary of the fixed two-window memory map
//   RV_OFF_LO / RV_OFF_HI: offsets subtracted in the low / high windows
//   xlate_*              : region-table field select, entry struct, reset table
package rv_pkg;

   localparam int          RV_XLEN     = 32;
   localparam int          RV_MEM_LEN  = 20;
   localparam logic [31:0] RV_MEM_GATE = 32'h000F_FFFF;
   localparam logic [31:0] RV_OFF_LO   = 32'h0001_0094;
   localparam logic [31:0] RV_OFF_HI   = 32'h7FEF_FDB0;

   localparam int XLATE_N_REGIONS = 4;

   typedef enum logic [1:0] {XF_BASE, XF_LIMIT, XF_OFFSET, XF_EN} xlate_field_e;

   typedef struct packed {
      logic [RV_XLEN-1:0] base;
      logic [RV_XLEN-1:0] limit;
      logic [RV_XLEN-1:0] offset;
      logic               en;
   } xlate_region_t;

   // Entries 0/1 rebuild the legacy two-window map; everything else starts disabled.
   function automatic xlate_region_t xlate_default(input int r);
      xlate_region_t e;
      e = '0;
      if (r == 0) begin
         e.limit  = RV_MEM_GATE - 32'd1;
         e.offset = RV_OFF_LO;
         e.en     = 1'b1;
      end else if (r == 1) begin
         e.base   = RV_MEM_GATE;
         e.limit  = 32'hFFFF_FFFF;
         e.offset = RV_OFF_HI;
         e.en     = 1'b1;
      end
      return e;
   endfunction

   localparam xlate_region_t XLATE_DEFAULT_TABLE [XLATE_N_REGIONS] = '{
      xlate_default(0), xlate_default(1), xlate_default(2), xlate_default(3)
   };

endpackage

// File: rtl/rv_xlate_region_match.sv
// rv_xlate_region_match: compare one address against one region table entry.
//   addr_i      : core address
//   region_i    : table entry {base, limit, offset, en}
//   hit_o       : enabled and base <= addr <= limit (unsigned)
//   underflow_o : addr below the region offset
//   diff_o      : addr - offset, full width (upper bits flag out-of-range)
module rv_xlate_region_match
   import rv_pkg::*;
#(
   parameter int XLEN = RV_XLEN
) (
   input  logic [XLEN-1:0] addr_i,
   input  xlate_region_t   region_i,
   output logic            hit_o,
   output logic            underflow_o,
   output logic [XLEN-1:0] diff_o
);

   // base > limit naturally yields no hit.
   assign hit_o       = region_i.en && (addr_i >= region_i.base) && (addr_i <= region_i.limit);
   assign underflow_o = addr_i < region_i.offset;
   assign diff_o      = addr_i - region_i.offset;

endmodule

// File: rtl/rv_addr_xlate.sv
// rv_addr_xlate: runtime-programmable N-region core->memory address translator.
//   clk_i, arstn_i            : clock, async active-low reset
//   req_valid_i/req_ready_o   : request handshake, req_addr_i core address
//   rsp_valid_o/rsp_ready_i   : result handshake (one registered stage)
//   rsp_addr_o/fault_o/region_o: translated address, fault flag, matched region
//   cfg_we_i/idx_i/field_i/wdata_i: region table write port
//   fault_cnt_o               : saturating count of faulting results loaded
module rv_addr_xlate
   import rv_pkg::*;
#(
   parameter int XLEN      = RV_XLEN,
   parameter int MEM_LEN   = RV_MEM_LEN,
   parameter int N_REGIONS = XLATE_N_REGIONS,
   parameter int CNT_W     = 16,
   localparam int IW       = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1
) (
   input  logic               clk_i,
   input  logic               arstn_i,
   input  logic               req_valid_i,
   output logic               req_ready_o,
   input  logic [XLEN-1:0]    req_addr_i,
   output logic               rsp_valid_o,
   input  logic               rsp_ready_i,
   output logic [MEM_LEN-1:0] rsp_addr_o,
   output logic               rsp_fault_o,
   output logic [IW-1:0]      rsp_region_o,
   input  logic               cfg_we_i,
   input  logic [IW-1:0]      cfg_idx_i,
   input  logic [1:0]         cfg_field_i,
   input  logic [XLEN-1:0]    cfg_wdata_i,
   output logic [CNT_W-1:0]   fault_cnt_o
);

   xlate_region_t          tbl_q [N_REGIONS];
   logic [N_REGIONS-1:0]   hit, unf;
   logic [XLEN-1:0]        diff [N_REGIONS];

   logic                   rsp_valid_q, rsp_fault_q;
   logic [MEM_LEN-1:0]     rsp_addr_q;
   logic [IW-1:0]          rsp_region_q;
   logic [CNT_W-1:0]       fault_cnt_q;

   logic                   fault_d, any_hit;
   logic [MEM_LEN-1:0]     addr_d;
   logic [IW-1:0]          region_d;
   logic                   accept;

   for (genvar g = 0; g < N_REGIONS; g++) begin : g_match
      rv_xlate_region_match #(.XLEN(XLEN)) u_match (
         .addr_i      (req_addr_i),
         .region_i    (tbl_q[g]),
         .hit_o       (hit[g]),
         .underflow_o (unf[g]),
         .diff_o      (diff[g])
      );
   end

   // Table writes are independent of the handshake; the compare path sees the
   // old table during the write cycle because tbl_q updates at the edge.
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         for (int r = 0; r < N_REGIONS; r++) tbl_q[r] <= xlate_default(r);
      end else if (cfg_we_i && (int'(cfg_idx_i) < N_REGIONS)) begin
         case (xlate_field_e'(cfg_field_i))
            XF_BASE:   tbl_q[cfg_idx_i].base   <= cfg_wdata_i;
            XF_LIMIT:  tbl_q[cfg_idx_i].limit  <= cfg_wdata_i;
            XF_OFFSET: tbl_q[cfg_idx_i].offset <= cfg_wdata_i;
            default:   tbl_q[cfg_idx_i].en     <= cfg_wdata_i[0];
         endcase
      end
   end

   // Priority encode: scanning downward leaves the lowest-index hit selected.
   always_comb begin
      region_d = '0;
      any_hit  = 1'b0;
      for (int r = N_REGIONS - 1; r >= 0; r--) begin
         if (hit[r]) begin
            region_d = IW'(r);
            any_hit  = 1'b1;
         end
      end
      fault_d = !any_hit || unf[region_d] || (|diff[region_d][XLEN-1:MEM_LEN]);
      addr_d  = fault_d ? '0 : diff[region_d][MEM_LEN-1:0];
   end

   assign req_ready_o = !rsp_valid_q || rsp_ready_i;
   assign accept      = req_valid_i && req_ready_o;

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         rsp_valid_q  <= 1'b0;
         rsp_addr_q   <= '0;
         rsp_fault_q  <= 1'b0;
         rsp_region_q <= '0;
         fault_cnt_q  <= '0;
      end else begin
         if (accept) begin
            rsp_valid_q  <= 1'b1;
            rsp_addr_q   <= addr_d;
            rsp_fault_q  <= fault_d;
            rsp_region_q <= region_d;
            if (fault_d && (fault_cnt_q != '1)) fault_cnt_q <= fault_cnt_q + 1'b1;
         end else if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
         end
      end
   end

   assign rsp_valid_o  = rsp_valid_q;
   assign rsp_addr_o   = rsp_addr_q;
   assign rsp_fault_o  = rsp_fault_q;
   assign rsp_region_o = rsp_region_q;
   assign fault_cnt_o  = fault_cnt_q;

endmodule

// File: tb/tb_rv_addr_xlate.sv
module tb_rv_addr_xlate;

   logic        clk_i = 1'b0;
   logic        arstn_i;
   logic        req_valid_i, req_ready_o;
   logic [31:0] req_addr_i;
   logic        rsp_valid_o, rsp_ready_i;
   logic [19:0] rsp_addr_o;
   logic        rsp_fault_o;
   logic [1:0]  rsp_region_o;
   logic        cfg_we_i;
   logic [1:0]  cfg_idx_i, cfg_field_i;
   logic [31:0] cfg_wdata_i;
   logic [15:0] fault_cnt_o;

   int checks = 0, failures = 0;

   rv_addr_xlate dut (
      .clk_i(clk_i), .arstn_i(arstn_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_addr_o(rsp_addr_o),
      .rsp_fault_o(rsp_fault_o), .rsp_region_o(rsp_region_o),
      .cfg_we_i(cfg_we_i), .cfg_idx_i(cfg_idx_i), .cfg_field_i(cfg_field_i),
      .cfg_wdata_i(cfg_wdata_i), .fault_cnt_o(fault_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   // Reference table and model: plain arithmetic over the region rules.
   logic [31:0] m_base [4], m_lim [4], m_off [4];
   bit          m_en [4];
   int          exp_cnt;

   task automatic model_reset();
      for (int r = 0; r < 4; r++) begin
         m_base[r] = 0; m_lim[r] = 0; m_off[r] = 0; m_en[r] = 0;
      end
      m_lim[0] = 32'h000F_FFFE; m_off[0] = 32'h0001_0094; m_en[0] = 1;
      m_base[1] = 32'h000F_FFFF; m_lim[1] = 32'hFFFF_FFFF; m_off[1] = 32'h7FEF_FDB0; m_en[1] = 1;
      exp_cnt = 0;
   endtask

   function automatic logic [22:0] pk(input bit f, input int rg, input logic [19:0] a);
      logic [1:0] r2;
      r2 = rg[1:0];
      return {f, r2, a};
   endfunction

   function automatic logic [22:0] model(input logic [31:0] a);
      int hit;
      longint d;
      hit = -1;
      for (int r = 0; r < 4; r++)
         if (hit < 0 && m_en[r] && a >= m_base[r] && a <= m_lim[r]) hit = r;
      if (hit < 0) return pk(1'b1, 0, 20'h0);
      d = longint'({32'h0, a}) - longint'({32'h0, m_off[hit]});
      if (d < 0 || d >= 64'd1048576) return pk(1'b1, hit, 20'h0);
      return pk(1'b0, hit, d[19:0]);
   endfunction

   function automatic logic [31:0] rnd_addr();
      case ($urandom_range(0, 3))
         0: return 32'h0001_0000 + $urandom_range(0, 32'h0001_FFFF);
         1: return 32'h7FEF_0000 + $urandom_range(0, 32'h0030_0000);
         2: return $urandom;
         default: return 32'h000F_FF00 + $urandom_range(0, 511);
      endcase
   endfunction

   function automatic logic [22:0] dut_out();
      return {rsp_fault_o, rsp_region_o, rsp_addr_o};
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic bump(input logic [22:0] e);
      if (e[22] && exp_cnt < 65535) exp_cnt++;
   endtask

   // One request with a free-flowing sink; result checked right after the accept edge.
   task automatic do_req(input string tag, input logic [31:0] a, input logic [22:0] exp);
      @(posedge clk_i); #1;
      req_valid_i = 1; req_addr_i = a; rsp_ready_i = 1;
      @(posedge clk_i); #1;
      req_valid_i = 0;
      chk({tag, "_vld"}, rsp_valid_o, 1);
      chk(tag, dut_out(), exp);
      chk({tag, "_model"}, dut_out(), model(a));
      bump(exp);
   endtask

   task automatic cfg_wr(input int idx, input int fld, input logic [31:0] d);
      @(posedge clk_i); #1;
      cfg_we_i = 1; cfg_idx_i = idx[1:0]; cfg_field_i = fld[1:0]; cfg_wdata_i = d;
      @(posedge clk_i); #1;
      cfg_we_i = 0;
      case (fld)
         0: m_base[idx] = d;
         1: m_lim[idx] = d;
         2: m_off[idx] = d;
         default: m_en[idx] = d[0];
      endcase
   endtask

   initial begin
      logic [22:0] q [$];
      logic [22:0] e, prev_out;
      bit prev_stall;
      int acc, cyc;

      arstn_i = 0; req_valid_i = 0; req_addr_i = 0; rsp_ready_i = 1;
      cfg_we_i = 0; cfg_idx_i = 0; cfg_field_i = 0; cfg_wdata_i = 0;
      model_reset();
      repeat (3) @(posedge clk_i);
      #1;
      chk("rst_vld", rsp_valid_o, 0);
      chk("rst_out", dut_out(), 0);
      chk("rst_cnt", fault_cnt_o, 0);
      chk("rst_rdy", req_ready_o, 1);
      arstn_i = 1;

      // Default-table directed cases
      do_req("win0",      32'h0001_1000, pk(0, 0, 20'h00F6C));
      do_req("win1",      32'h7FFF_0000, pk(0, 1, 20'hF0250));
      do_req("underflow", 32'h000F_FFFF, pk(1, 1, 20'h0));
      chk("cnt1", fault_cnt_o, 1);
      do_req("oor",       32'h8000_0000, pk(1, 1, 20'h0));
      do_req("r0_top",    32'h000F_FFFE, pk(0, 0, 20'hEFF6A));

      // Reprogramming
      cfg_wr(0, 3, 0);
      do_req("r0_off",    32'h0001_1000, pk(1, 0, 20'h0));
      cfg_wr(2, 0, 32'h0001_0000);
      cfg_wr(2, 1, 32'h0001_FFFF);
      cfg_wr(2, 2, 32'h0001_0000);
      cfg_wr(2, 3, 1);
      do_req("r2_hit",    32'h0001_1000, pk(0, 2, 20'h01000));

      // Write and request in the same cycle: request sees the old offset
      @(posedge clk_i); #1;
      cfg_we_i = 1; cfg_idx_i = 2; cfg_field_i = 2; cfg_wdata_i = 32'h0001_0800;
      req_valid_i = 1; req_addr_i = 32'h0001_1000; rsp_ready_i = 1;
      @(posedge clk_i); #1;
      cfg_we_i = 0; req_valid_i = 0;
      chk("same_cyc", dut_out(), pk(0, 2, 20'h01000));
      m_off[2] = 32'h0001_0800;
      do_req("new_off",   32'h0001_1000, pk(0, 2, 20'h00800));
      chk("cnt_dir", fault_cnt_o, exp_cnt);

      // Stall for 5 cycles with a pending request behind it
      @(posedge clk_i); #1;
      req_valid_i = 1; req_addr_i = 32'h7FFF_0000; rsp_ready_i = 0;
      @(posedge clk_i); #1;
      req_addr_i = 32'h0001_1000;
      // A write to the region behind the held result must not disturb it
      cfg_we_i = 1; cfg_idx_i = 1; cfg_field_i = 2; cfg_wdata_i = 32'h7FFF_0000;
      @(posedge clk_i); #1;
      cfg_we_i = 0; m_off[1] = 32'h7FFF_0000;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_i);
         chk("stall_rdy", req_ready_o, 0);
         chk("stall_vld", rsp_valid_o, 1);
         chk("stall_out", dut_out(), pk(0, 1, 20'hF0250));
      end
      @(posedge clk_i); #1;
      req_valid_i = 0; rsp_ready_i = 1;
      repeat (2) @(posedge clk_i);

      // Random stream with random backpressure against the model
      acc = 0; cyc = 0; prev_stall = 0; prev_out = 0;
      while (acc < 100 && cyc < 3000) begin
         @(posedge clk_i); #1;
         req_valid_i = ($urandom_range(0, 3) != 0);
         req_addr_i  = rnd_addr();
         rsp_ready_i = ($urandom_range(0, 3) != 0);
         @(negedge clk_i);
         if (prev_stall) begin
            chk("hold_vld", rsp_valid_o, 1);
            chk("hold_out", dut_out(), prev_out);
         end
         chk("ready_rule", req_ready_o, !rsp_valid_o || rsp_ready_i);
         if (rsp_valid_o && rsp_ready_i) begin
            if (q.size() == 0) chk("spurious", 1, 0);
            else chk("stream", dut_out(), q.pop_front());
         end
         if (req_valid_i && req_ready_o) begin
            e = model(req_addr_i);
            q.push_back(e);
            bump(e);
            acc++;
         end
         prev_stall = rsp_valid_o && !rsp_ready_i;
         prev_out = dut_out();
         cyc++;
      end
      chk("stream_acc", acc, 100);
      cyc = 0;
      while (q.size() > 0 && cyc < 20) begin
         @(posedge clk_i); #1;
         req_valid_i = 0; rsp_ready_i = 1;
         @(negedge clk_i);
         if (rsp_valid_o) chk("drain", dut_out(), q.pop_front());
         cyc++;
      end
      chk("drain_empty", q.size(), 0);
      @(posedge clk_i); #1;
      chk("drain_vld", rsp_valid_o, 0);
      chk("cnt_stream", fault_cnt_o, exp_cnt);

      // Reset in the middle of a stall
      @(posedge clk_i); #1;
      req_valid_i = 1; req_addr_i = 32'h7FFF_0000; rsp_ready_i = 0;
      @(posedge clk_i); #1;
      req_valid_i = 0;
      chk("pre_rst_vld", rsp_valid_o, 1);
      #2 arstn_i = 0;
      #1;
      chk("mid_rst_vld", rsp_valid_o, 0);
      chk("mid_rst_out", dut_out(), 0);
      chk("mid_rst_cnt", fault_cnt_o, 0);
      model_reset();
      @(posedge clk_i); #1;
      arstn_i = 1; rsp_ready_i = 1;
      do_req("post_rst0", 32'h0001_1000, pk(0, 0, 20'h00F6C));
      do_req("post_rst2", 32'h0001_5000, pk(0, 0, 20'h04F6C));

      // Saturate the fault counter
      @(posedge clk_i); #1;
      req_valid_i = 1; req_addr_i = 32'h8000_0000; rsp_ready_i = 1;
      repeat (65534) @(posedge clk_i);
      #1;
      chk("cnt_fffe", fault_cnt_o, 16'hFFFE);
      @(posedge clk_i); #1;
      chk("cnt_ffff", fault_cnt_o, 16'hFFFF);
      repeat (5) @(posedge clk_i);
      #1;
      chk("cnt_sat", fault_cnt_o, 16'hFFFF);
      req_valid_i = 0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
